// File: rtl/plps_pkg.sv
// Shared definitions for the PL-side capture path: capture FSM encoding and
// default buffer geometry.
package plps_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_ARMED   = 2'd1,
      CAP_CAPTURE = 2'd2,
      CAP_DONE    = 2'd3
   } cap_state_t;

   localparam int unsigned DATAWIDTH_DEF  = 64;
   localparam int unsigned ADDRWIDTH_DEF  = 32;
   localparam int unsigned DEPTH_LOG2_DEF = 12;
   localparam int unsigned BYTES_PER_WORD = DATAWIDTH_DEF / 8;
   localparam int unsigned DEPTH          = 1 << DEPTH_LOG2_DEF;

endpackage

// File: rtl/adc_bram_capture_if.sv
// ADC stream input and BRAM write port of the capture engine, bundled together.
// master = capture engine side, slave = ADC source / BRAM side.
interface adc_bram_capture_if #(
   parameter int unsigned ADDRW = 32,
   parameter int unsigned DW    = 64
) ();
   logic [DW-1:0]   tdata;
   logic            tvalid;
   logic            tready;
   logic            en;
   logic [DW/8-1:0] we;
   logic [ADDRW-1:0] addr;
   logic [DW-1:0]   din;

   modport master (
      input  tdata, tvalid,
      output tready,
      output en, we, addr, din
   );

   modport slave (
      output tdata, tvalid,
      input  tready,
      input  en, we, addr, din
   );
endinterface

// File: rtl/capture_decim.sv
// Keep-1-of-(decim+1) counter; keep flags the accepted beat that lands on count 0.
module capture_decim
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       clr,
   input  logic       valid,
   input  logic [7:0] decim,
   output logic       keep
);

   logic [7:0] cnt;

   assign keep = valid && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         cnt <= '0;
      end else if (valid) begin
         cnt <= (cnt == decim) ? '0 : cnt + 8'd1;
      end
   end

endmodule

// File: rtl/adc_bram_capture.sv
// Arm/trigger capture of an ADC stream into the host-readable BRAM, with optional
// decimation and busy/done/count status for host polling.
module adc_bram_capture
   import plps_pkg::*;
#(
   parameter int unsigned ADC_AXIS_DATAWIDTH   = DATAWIDTH_DEF,
   parameter int unsigned BRAMTOHOST_ADDRWIDTH = ADDRWIDTH_DEF,
   parameter int unsigned BRAMTOHOST_DATAWIDTH = DATAWIDTH_DEF,
   parameter int unsigned DEPTH_LOG2           = DEPTH_LOG2_DEF
)
(
   input  logic                    clk,
   input  logic                    resetn,
   adc_bram_capture_if.master      bus,
   input  logic                    arm,
   input  logic                    trigger,
   input  logic [DEPTH_LOG2:0]     nsamples,
   input  logic [7:0]              decim,
   output logic                    busy,
   output logic                    done,
   output logic [DEPTH_LOG2:0]     wr_count
);

   localparam int unsigned CW         = DEPTH_LOG2 + 1;
   localparam int unsigned WORD_BYTES = BRAMTOHOST_DATAWIDTH / 8;
   localparam int unsigned BUF_DEPTH  = 1 << DEPTH_LOG2;

   cap_state_t state, state_nxt;

   logic [CW-1:0]                   target_q;
   logic [CW-1:0]                   target_clamped;
   logic [7:0]                      decim_q;
   logic [ADC_AXIS_DATAWIDTH-1:0]   beat;
   logic                            start;
   logic                            take;
   logic                            keep;

   assign bus.tready = resetn;
   assign beat       = bus.tdata;

   assign target_clamped = ((nsamples == '0) || (nsamples > CW'(BUF_DEPTH)))
                           ? CW'(BUF_DEPTH) : nsamples;

   // The trigger cycle itself is a capture cycle, so a beat present with the
   // trigger is the first one stored. Arm always wins over any beat.
   assign start = (state == CAP_ARMED) && trigger && !arm;
   assign take  = !arm && bus.tvalid &&
                  (start || ((state == CAP_CAPTURE) && (wr_count != target_q)));

   capture_decim u_decim (
      .clk    (clk),
      .resetn (resetn),
      .clr    (arm),
      .valid  (take),
      .decim  (decim_q),
      .keep   (keep)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= CAP_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         CAP_IDLE: ;
         CAP_ARMED: begin
            busy = 1'b1;
            if (trigger) state_nxt = CAP_CAPTURE;
         end
         CAP_CAPTURE: begin
            busy = 1'b1;
            if (wr_count == target_q) state_nxt = CAP_DONE;
         end
         CAP_DONE: done = 1'b1;
         default: state_nxt = CAP_IDLE;
      endcase
      if (arm) state_nxt = CAP_ARMED;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.en   <= 1'b0;
         bus.we   <= '0;
         bus.addr <= '0;
         bus.din  <= '0;
         wr_count <= '0;
         target_q <= '0;
         decim_q  <= '0;
      end else begin
         bus.en <= keep;
         bus.we <= keep ? '1 : '0;
         if (keep) begin
            bus.addr <= BRAMTOHOST_ADDRWIDTH'(wr_count) * BRAMTOHOST_ADDRWIDTH'(WORD_BYTES);
            bus.din  <= BRAMTOHOST_DATAWIDTH'(beat);
         end
         if (arm) begin
            wr_count <= '0;
            target_q <= target_clamped;
            decim_q  <= decim;
         end else if (keep) begin
            wr_count <= wr_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_bram_capture.sv
// Scoreboard bench for adc_bram_capture: directed captures push expected BRAM
// writes; a monitor pops and compares every bram_en cycle.
module tb_adc_bram_capture;
   import plps_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] din;
   } wr_t;

   logic        clk      = 1'b0;
   logic        resetn   = 1'b0;
   logic        arm      = 1'b0;
   logic        trigger  = 1'b0;
   logic [12:0] nsamples = '0;
   logic [7:0]  decim    = '0;
   logic        busy;
   logic        done;
   logic [12:0] wr_count;

   int checks = 0;
   int errors = 0;
   wr_t exp_q[$];

   adc_bram_capture_if #(.ADDRW(32), .DW(64)) bus ();

   adc_bram_capture #(
      .ADC_AXIS_DATAWIDTH   (64),
      .BRAMTOHOST_ADDRWIDTH (32),
      .BRAMTOHOST_DATAWIDTH (64),
      .DEPTH_LOG2           (12)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .arm      (arm),
      .trigger  (trigger),
      .nsamples (nsamples),
      .decim    (decim),
      .busy     (busy),
      .done     (done),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.en === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0h din=%0h expected no write",
                        bus.addr, bus.din);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(bus.addr), 64'(e.addr));
               chk("wr_din", bus.din, e.din);
               chk("wr_we", 64'(bus.we), 64'hFF);
            end
         end
      end
   endtask

   task automatic push_seq(input int n, input int base, input int step);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{addr: 32'(i * 8), din: 64'(base + i * step)});
   endtask

   task automatic do_arm(input int ns, input int dc);
      arm      = 1'b1;
      nsamples = 13'(ns);
      decim    = 8'(dc);
      tick();
      arm = 1'b0;
   endtask

   task automatic stream(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         bus.tdata  = 64'(base + k);
         bus.tvalid = 1'b1;
         trigger    = (k == 0);
         tick();
      end
      trigger    = 1'b0;
      bus.tvalid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("done", 64'(done), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      bus.tdata  = '0;
      bus.tvalid = 1'b0;
      fork
         monitor();
      join_none

      // reset state
      repeat (3) tick();
      chk("rst_en", 64'(bus.en), 64'd0);
      chk("rst_we", 64'(bus.we), 64'd0);
      chk("rst_addr", 64'(bus.addr), 64'd0);
      chk("rst_din", bus.din, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wr_count", 64'(wr_count), 64'd0);
      chk("rst_tready", 64'(bus.tready), 64'd0);
      resetn = 1'b1;
      tick();
      chk("tready", 64'(bus.tready), 64'd1);

      // 1: nsamples=4, decim=0
      do_arm(4, 0);
      chk("armed_busy", 64'(busy), 64'd1);
      chk("armed_done", 64'(done), 64'd0);
      push_seq(4, 0, 1);
      stream(8, 0);
      wait_done(20);
      chk("t1_wr_count", 64'(wr_count), 64'd4);

      // 2: decim=2 keeps every third beat
      do_arm(3, 2);
      chk("rearm_done_clr", 64'(done), 64'd0);
      chk("rearm_count_clr", 64'(wr_count), 64'd0);
      push_seq(3, 0, 3);
      stream(21, 0);
      wait_done(20);
      chk("t2_wr_count", 64'(wr_count), 64'd3);

      // 3: nsamples=0 means full depth
      do_arm(0, 0);
      push_seq(4096, 0, 1);
      stream(4116, 0);
      wait_done(10);
      chk("t3_wr_count", 64'(wr_count), 64'd4096);
      chk("t3_last_addr", 64'(bus.addr), 64'h7FF8);

      // 4: arm with trigger in the same cycle drops the trigger
      arm        = 1'b1;
      trigger    = 1'b1;
      nsamples   = 13'd2;
      decim      = 8'd0;
      bus.tvalid = 1'b1;
      bus.tdata  = 64'd99;
      tick();
      arm     = 1'b0;
      trigger = 1'b0;
      repeat (4) tick();
      bus.tvalid = 1'b0;
      chk("t4_still_armed", 64'(busy), 64'd1);
      chk("t4_done", 64'(done), 64'd0);
      chk("t4_wr_count", 64'(wr_count), 64'd0);
      push_seq(2, 50, 1);
      stream(6, 50);
      wait_done(20);

      // 5: gappy tvalid
      do_arm(2, 0);
      exp_q.push_back('{addr: 32'd0, din: 64'd10});
      exp_q.push_back('{addr: 32'd8, din: 64'd12});
      for (int k = 0; k < 8; k++) begin
         bus.tdata  = 64'(10 + k);
         bus.tvalid = (k % 2 == 0);
         trigger    = (k == 0);
         tick();
      end
      trigger    = 1'b0;
      bus.tvalid = 1'b0;
      wait_done(20);
      chk("t5_wr_count", 64'(wr_count), 64'd2);

      // 6: reset mid-capture after two writes
      do_arm(8, 0);
      push_seq(2, 0, 1);
      bus.tdata  = 64'd0;
      bus.tvalid = 1'b1;
      trigger    = 1'b1;
      tick();
      trigger   = 1'b0;
      bus.tdata = 64'd1;
      tick();
      resetn    = 1'b0;
      bus.tdata = 64'd2;
      tick();
      bus.tvalid = 1'b0;
      chk("t6_en_dropped", 64'(bus.en), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_wr_count", 64'(wr_count), 64'd0);
      chk("t6_tready", 64'(bus.tready), 64'd0);
      resetn = 1'b1;
      tick();
      do_arm(3, 0);
      push_seq(3, 100, 1);
      stream(5, 100);
      wait_done(20);
      chk("t6_rearm_count", 64'(wr_count), 64'd3);

      repeat (5) tick();
      chk("final_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
